// File: rtl/relu_map_streamer_pkg.sv
// Shared geometry, widths and FSM state type for the ReLU feature-map streamer.
package relu_map_streamer_pkg;

  localparam int unsigned ELEMS   = 676;
  localparam int unsigned WIDTH   = 20;
  localparam int unsigned ROW_LEN = 26;
  localparam int unsigned IDX_W   = $clog2(ELEMS);
  localparam int unsigned RC_W    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

endpackage

// File: rtl/relu_map_addr_ctr.sv
// Row/column/linear-index counter walking the feature map in row-major order.
module relu_map_addr_ctr
  import relu_map_streamer_pkg::*;
#(
  parameter int unsigned ROW_LEN = relu_map_streamer_pkg::ROW_LEN,
  parameter int unsigned ELEMS   = relu_map_streamer_pkg::ELEMS,
  parameter int unsigned IDX_W   = relu_map_streamer_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [RC_W-1:0]  row,
  output logic [RC_W-1:0]  col,
  output logic [IDX_W-1:0] idx,
  output logic             eol,
  output logic             last
);

  logic [RC_W-1:0]  row_q, row_d;
  logic [RC_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign eol  = (col_q == RC_W'(ROW_LEN - 1));
  assign last = (idx_q == IDX_W'(ELEMS - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    idx_d = idx_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
      idx_d = '0;
    end else if (inc) begin
      if (last) begin
        // Wrap fully so the buffer read index never leaves the frame.
        row_d = '0;
        col_d = '0;
        idx_d = '0;
      end else if (eol) begin
        row_d = row_q + 1'b1;
        col_d = '0;
        idx_d = idx_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      idx_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      idx_q <= idx_d;
    end
  end

  assign row = row_q;
  assign col = col_q;
  assign idx = idx_q;

endmodule

// File: rtl/relu_map_streamer.sv
// Captures a parallel post-ReLU feature map in one cycle and streams it out element by
// element over a valid/ready interface with row/column tags.
module relu_map_streamer
  import relu_map_streamer_pkg::*;
#(
  parameter int unsigned ELEMS   = relu_map_streamer_pkg::ELEMS,
  parameter int unsigned WIDTH   = relu_map_streamer_pkg::WIDTH,
  parameter int unsigned ROW_LEN = relu_map_streamer_pkg::ROW_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] map_in [ELEMS],
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RC_W-1:0]         out_row,
  output logic [RC_W-1:0]         out_col,
  output logic                    out_eol,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_neg
);

  localparam int unsigned IDX_W = $clog2(ELEMS);

  state_e state_q, state_d;

  logic signed [WIDTH-1:0] frame_q [ELEMS];
  logic                    err_neg_q;
  logic                    capture;
  logic                    xfer;
  logic                    any_neg;
  logic [IDX_W-1:0]        idx;
  logic                    ctr_eol;
  logic                    ctr_last;

  relu_map_addr_ctr #(
    .ROW_LEN (ROW_LEN),
    .ELEMS   (ELEMS),
    .IDX_W   (IDX_W)
  ) u_addr_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (capture),
    .inc  (xfer),
    .row  (out_row),
    .col  (out_col),
    .idx  (idx),
    .eol  (ctr_eol),
    .last (ctr_last)
  );

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          capture = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        out_valid = 1'b1;
        if (out_ready && ctr_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign xfer = out_valid & out_ready;
  assign busy = (state_q == StStream) || (state_q == StDone);

  always_comb begin
    any_neg = 1'b0;
    for (int i = 0; i < int'(ELEMS); i++) begin
      any_neg = any_neg | map_in[i][WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      err_neg_q <= 1'b0;
      for (int i = 0; i < int'(ELEMS); i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (capture) begin
        err_neg_q <= any_neg;
        for (int i = 0; i < int'(ELEMS); i++) begin
          frame_q[i] <= map_in[i];
        end
      end
    end
  end

  // Tags are qualified by valid so they read 0 outside STREAM.
  assign out_data = frame_q[idx];
  assign out_eol  = out_valid & ctr_eol;
  assign out_last = out_valid & ctr_last;
  assign err_neg  = err_neg_q;

endmodule

// File: tb/tb_relu_map_streamer.sv
// Scoreboard bench for relu_map_streamer: frames pushed on start, monitor pops on handshakes.
module tb_relu_map_streamer;

  localparam int N    = 676;
  localparam int ROWL = 26;

  typedef struct packed {
    logic signed [19:0] data;
    logic [4:0]         row;
    logic [4:0]         col;
    logic               eol;
    logic               last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [19:0] map_in [N];
  logic signed [19:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [4:0]         out_row;
  logic [4:0]         out_col;
  logic               out_eol;
  logic               out_last;
  logic               busy;
  logic               done;
  logic               err_neg;

  exp_t sb_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   xfer_total = 0;
  int   done_cnt   = 0;
  int   stall_cnt  = 0;
  logic toggle_en  = 1'b0;
  logic held_v     = 1'b0;
  exp_t held;

  relu_map_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .map_in    (map_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_eol   (out_eol),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err_neg   (err_neg)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_en ? ~out_ready : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, req, req);
    end
  endtask

  // Monitor: compares every accepted element against the scoreboard and every stall for stability.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    act = {out_data, out_row, out_col, out_eol, out_last};
    if (done) done_cnt++;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (out_valid && held_v) check("stall_hold", act, held);
      held_v = 1'b0;
      if (out_valid && !out_ready) begin
        held_v = 1'b1;
        held   = act;
        stall_cnt++;
      end
      if (out_valid && out_ready) begin
        xfer_total++;
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected: got data=%0d row=%0d col=%0d, expected no output",
                   out_data, out_row, out_col);
        end else begin
          e = sb_q.pop_front();
          vectors++;
          if (act !== e) begin
            miscompares++;
            $display("FAIL sb_elem: got data=%0d row=%0d col=%0d eol=%0b last=%0b, expected data=%0d row=%0d col=%0d eol=%0b last=%0b",
                     out_data, out_row, out_col, out_eol, out_last,
                     e.data, e.row, e.col, e.eol, e.last);
          end
        end
      end
    end
  end

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.data = map_in[i];
      e.row  = 5'(i / ROWL);
      e.col  = 5'(i % ROWL);
      e.eol  = ((i % ROWL) == ROWL - 1);
      e.last = (i == N - 1);
      sb_q.push_back(e);
    end
  endtask

  // Returns with the bench in the first STREAM cycle (element 0 presented).
  task automatic start_frame();
    push_frame();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, inout int cyc);
    int guard = 0;
    while (!done && guard < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      guard++;
    end
    if (!done) check({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_xfers(input string name, input int target);
    int guard = 0;
    while (xfer_total < target && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (xfer_total < target) check({name, "_xfer_timeout"}, 32'(xfer_total), 32'(target));
  endtask

  initial begin
    int cyc;
    int base;
    int dn;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++) map_in[i] = 20'sd77;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_neg", 32'(err_neg), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_rowcol", 32'({out_row, out_col}), 32'd0);
    check("rst_eol_last", 32'({out_eol, out_last}), 32'd0);
    rst = 1'b0;

    // Frame A: ramp, ready held high, latency and total frame time.
    for (int i = 0; i < N; i++) map_in[i] = 20'(i);
    base = xfer_total;
    cyc  = 1;
    start_frame();
    cyc++;
    check("a_valid_after_start", 32'(out_valid), 32'd1);
    check("a_err_neg", 32'(err_neg), 32'd0);
    wait_done("a", cyc);
    check("a_done_cycle", 32'(cyc), 32'd678);
    check("a_busy_in_done", 32'(busy), 32'd1);
    check("a_valid_in_done", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("a_done_one_cycle", 32'(done), 32'd0);
    check("a_busy_idle", 32'(busy), 32'd0);
    check("a_xfers", 32'(xfer_total - base), 32'(N));
    check("a_sb_empty", 32'(sb_q.size()), 32'd0);

    // Frame B: out_ready toggling every cycle.
    for (int i = 0; i < N; i++) map_in[i] = 20'(3 * i + 11);
    base      = xfer_total;
    cyc       = 1;
    toggle_en = 1'b1;
    start_frame();
    wait_done("b", cyc);
    toggle_en = 1'b0;
    @(posedge clk);
    #1;
    check("b_xfers", 32'(xfer_total - base), 32'(N));
    check("b_sb_empty", 32'(sb_q.size()), 32'd0);
    check("b_stalls_seen", 32'(stall_cnt >= 600), 32'd1);

    // Frame C: one negative element; second start with changed map_in mid-frame.
    for (int i = 0; i < N; i++) map_in[i] = 20'(i + 1);
    map_in[100] = -20'sd5;
    base = xfer_total;
    cyc  = 1;
    start_frame();
    check("c_err_neg_set", 32'(err_neg), 32'd1);
    wait_xfers("c", base + 300);
    for (int i = 0; i < N; i++) map_in[i] = 20'sd12345;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("c_still_busy", 32'(busy), 32'd1);
    wait_done("c", cyc);
    @(posedge clk);
    #1;
    check("c_xfers", 32'(xfer_total - base), 32'(N));
    check("c_sb_empty", 32'(sb_q.size()), 32'd0);
    check("c_err_neg_held", 32'(err_neg), 32'd1);

    // Frame D: reset mid-frame, then restart immediately after reset.
    for (int i = 0; i < N; i++) map_in[i] = 20'(i + 7);
    base = xfer_total;
    start_frame();
    check("d_err_neg_cleared", 32'(err_neg), 32'd0);
    wait_xfers("d", base + 400);
    rst = 1'b1;
    sb_q.delete();
    dn = done_cnt;
    @(posedge clk);
    #1;
    check("d_rst_valid", 32'(out_valid), 32'd0);
    check("d_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) map_in[i] = 20'(500 + i);
    base = xfer_total;
    cyc  = 1;
    start_frame();
    cyc++;
    check("d_restart_valid", 32'(out_valid), 32'd1);
    check("d_no_done_on_abort", 32'(done_cnt), 32'(dn));
    wait_done("d", cyc);
    check("d_restart_cycle", 32'(cyc), 32'd678);
    @(posedge clk);
    #1;
    check("d_xfers", 32'(xfer_total - base), 32'(N));
    check("d_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/relu_map_streamer.md
RELU_MAP_STREAMER -- requirements
Module: relu_map_streamer

Interface
REQ-001 Parameter ELEMS, default 676, SHALL set the number of feature-map elements captured per frame.
REQ-002 Parameter WIDTH, default 20, SHALL set the signed element width in bits.
REQ-003 Parameter ROW_LEN, default 26, SHALL set the elements per row; ELEMS SHALL equal ROW_LEN*ROW_LEN.
REQ-004 clk  in  1  clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  SHALL request capture of map_in; it is honoured only in IDLE.
REQ-007 map_in  in  ELEMS x WIDTH signed  SHALL carry the parallel post-ReLU feature map (element 0 = row 0, col 0; row-major).
REQ-008 out_data  out  WIDTH signed  SHALL carry the current streamed element.
REQ-009 out_valid  out  1  SHALL indicate out_data is valid.
REQ-010 out_ready  in  1  SHALL indicate the downstream consumer accepts out_data.
REQ-011 out_row, out_col  out  5 each  SHALL give the row and column of out_data.
REQ-012 out_eol  out  1  SHALL be high with out_valid when out_col = ROW_LEN-1.
REQ-013 out_last  out  1  SHALL be high with out_valid when the element index = ELEMS-1.
REQ-014 busy  out  1  SHALL be high in STREAM and DONE.
REQ-015 done  out  1  SHALL be a one-cycle pulse on frame completion.
REQ-016 err_neg  out  1  SHALL flag a negative element in the captured frame.

Function
REQ-017 FSM states SHALL be IDLE, STREAM, DONE; IDLE -> STREAM on start; STREAM -> DONE on the handshake with out_last=1; DONE -> IDLE unconditionally after one cycle.
REQ-018 When start=1 in IDLE, all ELEMS elements SHALL be registered into an internal frame buffer in that cycle; index, row, and col SHALL be cleared to 0.
REQ-019 Latency: out_valid SHALL rise in the cycle after start is accepted, with element 0 presented.
REQ-020 A transfer SHALL occur only when out_valid=1 and out_ready=1 in the same cycle; the index SHALL then advance by 1.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_row, out_col, out_eol, and out_last SHALL hold stable.
REQ-022 On each transfer, col SHALL increment; at col = ROW_LEN-1, col SHALL wrap to 0 and row SHALL increment.
REQ-023 out_valid SHALL be 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-024 start in STREAM or DONE SHALL be ignored; changes on map_in after capture SHALL not affect the streamed data.
REQ-025 err_neg SHALL be set at capture if any map_in element has MSB=1; it SHALL stay set until the next accepted start or rst; data SHALL be streamed unmodified.
REQ-026 With out_ready held at 1, one frame SHALL take exactly ELEMS+2 cycles from start to the done pulse.

Reset
REQ-027 When rst=1, the FSM SHALL go to IDLE, and out_valid, out_eol, out_last, busy, done, and err_neg SHALL go to 0.
REQ-028 When rst=1, out_data, out_row, out_col, the index, and the frame buffer SHALL go to 0.
REQ-029 rst during STREAM SHALL abort the frame with no done pulse; a start in the first cycle after rst deassertion SHALL be accepted.

Structure
REQ-030 A shared package SHALL hold ELEMS, WIDTH, ROW_LEN, the FSM state enum, and the index, row, and col widths.
REQ-031 The row/col/index counter SHALL be a sub-module named relu_map_addr_ctr, with ports clr, inc, row, col, idx, and eol/last flags.

Verification
REQ-032 map_in[i]=i, start pulse, out_ready=1 -> out_data 0..675 in order; out_eol at cols 25; out_last at idx 675 (row 25, col 25); done at cycle 678.
REQ-033 out_ready toggled 1,0 every cycle -> each element held stable while out_ready=0; 676 transfers total with no loss or duplication.
REQ-034 map_in[100] = -5, all other elements positive -> err_neg=1 after capture; element 100 streamed as -5.
REQ-035 Second start pulse at transfer 300, with map_in changed -> ignored; original frame completes unaltered.
REQ-036 rst asserted at transfer 400 -> next cycle out_valid=0, busy=0, no done pulse; a new start streams from element 0.
